// File: rtl/wb_mem_responder.sv
// Wishbone responder backed by a 16-bit on-chip RAM with programmable first-beat wait states.
// Define WB_RESP_BURST_EN to honour the 4/8-beat burst hints and enable the no-wait STREAM path.
module wb_mem_responder #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [15:0]       wb_i_dat,
  input  logic [1:0]        wb_sel,
  input  logic              wb_4_burst,
  input  logic              wb_8_burst,
  output logic [15:0]       wb_o_dat,
  output logic              wb_ack,
  output logic              wb_err,
  output logic              wb_rty
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;
`ifdef WB_RESP_BURST_EN
  localparam logic [1:0] StStream = 2'd3;
`endif
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  logic [15:0] mem [2**DEPTH_LOG2];

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [3:0]        beats_q, beats_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       wdat_q, wdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [15:0]       rdat_q, rdat_d;
  logic              req, first, fast, in_range;
  logic [3:0]        req_len;

  // Registered ack/err mask the strobe so a held stb is not taken twice.
  assign req = wb_cyc & wb_stb & ~ack_q & ~err_q;

`ifdef WB_RESP_BURST_EN
  logic [ADDR_W-1:0] pred_q, pred_d;

  always_comb begin
    req_len = 4'd1;
    if (wb_8_burst) begin
      req_len = 4'd8;
    end else if (wb_4_burst) begin
      req_len = 4'd4;
    end
  end
`else
  logic unused_hints;
  assign unused_hints = wb_4_burst | wb_8_burst;
  assign req_len      = 4'd1;
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = 16'h0000;
    first    = 1'b0;
    fast     = 1'b0;
    in_range = 1'b0;
`ifdef WB_RESP_BURST_EN
    pred_d   = pred_q;
`endif

    case (state_q)
      StIdle: begin
        if (req) first = 1'b1;
      end
      StWait: begin
        if (!wb_cyc) begin
          state_d = StIdle;
        end else if (wait_q <= 4'd1) begin
          wait_d  = 4'd0;
          state_d = StResp;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StResp: begin
        beats_d = beats_q - 4'd1;
        state_d = StIdle;
`ifdef WB_RESP_BURST_EN
        if (beats_d != 4'd0) begin
          state_d = StStream;
          pred_d  = addr_q + ADDR_W'(1);
        end
`endif
      end
`ifdef WB_RESP_BURST_EN
      StStream: begin
        if (!wb_cyc) begin
          state_d = StIdle;
        end else if (req) begin
          if (wb_adr == pred_q) fast = 1'b1;
          else first = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (first || fast) begin
      addr_d = wb_adr;
      we_d   = wb_we;
      sel_d  = wb_sel;
      wdat_d = wb_i_dat;
    end
    if (first) begin
      beats_d = req_len;
      wait_d  = WaitInit;
      state_d = (WaitInit == 4'd0) ? StResp : StWait;
    end
    if (fast) state_d = StResp;

    // Outputs are registered on the edge that enters RESP.
    if (state_d == StResp) begin
      in_range = (addr_d[ADDR_W-1:DEPTH_LOG2] == '0);
      ack_d    = in_range;
      err_d    = ~in_range;
      if (in_range && !we_d) rdat_d = mem[addr_d[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      beats_q <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      wdat_q  <= 16'h0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 16'h0000;
`ifdef WB_RESP_BURST_EN
      pred_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beats_q <= beats_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
`ifdef WB_RESP_BURST_EN
      pred_q  <= pred_d;
`endif
    end
  end

  // Write lands at the edge closing the ack cycle; a reset on that edge drops it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state_q == StResp && ack_q && we_q) begin
      if (sel_q[0]) mem[addr_q[DEPTH_LOG2-1:0]][7:0]  <= wdat_q[7:0];
      if (sel_q[1]) mem[addr_q[DEPTH_LOG2-1:0]][15:8] <= wdat_q[15:8];
    end
  end

  assign wb_o_dat = rdat_q;
  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign wb_rty   = 1'b0;

endmodule
